prescaled_counter: RTL and testbench

//  Parametrised modulo-N up/down counter with built-in prescaler, clocked directly from CLOCK_50.

---
 rtl/prescaled_counter_if.sv | 23 ++
 rtl/prescaled_counter.sv | 71 +++++++
 tb/tb_prescaled_counter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/prescaled_counter_if.sv
// Control and status bundle for the prescaled counter.
// The driver side owns the controls; the counter side owns Q, tick and tc.
interface prescaled_counter_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] Q;
  logic             tick;
  logic             tc;

  modport master (
    output enable, up, load, load_value,
    input  Q, tick, tc
  );

  modport slave (
    input  enable, up, load, load_value,
    output Q, tick, tc
  );
endinterface

// File: rtl/prescaled_counter.sv
// Modulo-N up/down counter stepped by an internal prescaler tick.
// All state runs on CLOCK_50; tick is a one-cycle enable, not a clock.
module prescaled_counter #(
  parameter int WIDTH    = 8,
  parameter int DIV      = 25_000_000,
  parameter int MODULUS  = 256,
  parameter int SATURATE = 0
) (
  input logic                 CLOCK_50,
  input logic                 reset,
  prescaled_counter_if.slave  io
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  if (DIV < 1) begin : g_bad_div
    $error("prescaled_counter: DIV must be >= 1");
  end
  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_mod
    $error("prescaled_counter: MODULUS out of range");
  end

  logic [PW-1:0]    pre;
  logic [WIDTH-1:0] q;
  logic             tc_r;
  logic             tick;
  logic [WIDTH-1:0] clamped;
  logic             at_end;

  // step strobe: last prescaler phase, suppressed by reset and load
  assign tick = io.enable & (pre == PRE_LAST) & ~reset & ~io.load;

  // load values above the range clamp to the top count
  assign clamped = (io.load_value > MAXV) ? MAXV : io.load_value;

  // the pending step would leave the range in its direction
  assign at_end = io.up ? (q == MAXV) : (q == '0);

  assign io.Q    = q;
  assign io.tick = tick;
  assign io.tc   = tc_r;

  // prescaler, count and terminal-count pulse: reset > load > step > hold
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pre  <= '0;
      q    <= '0;
      tc_r <= 1'b0;
    end else if (io.load) begin
      pre  <= '0;
      q    <= clamped;
      tc_r <= 1'b0;
    end else begin
      tc_r <= 1'b0;
      if (io.enable) begin
        pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
      end
      if (tick) begin
        tc_r <= at_end;
        if (at_end) begin
          if (SATURATE == 0) begin
            q <= io.up ? '0 : MAXV;
          end
        end else begin
          q <= io.up ? q + 1'b1 : q - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_prescaled_counter.sv
// Bench for prescaled_counter: wrap and saturate instances driven together.
// Directed steps followed by random traffic, both checked against a count model.
module tb_prescaled_counter;
  localparam int W = 4;
  localparam int D = 4;
  localparam int M = 10;

  logic clk = 1'b0;
  logic rst;
  logic en, up, ld;
  logic [W-1:0] lv;

  always #5 clk = ~clk;

  prescaled_counter_if #(.WIDTH(W)) bw ();
  prescaled_counter_if #(.WIDTH(W)) bs ();

  assign bw.enable = en;
  assign bw.up = up;
  assign bw.load = ld;
  assign bw.load_value = lv;
  assign bs.enable = en;
  assign bs.up = up;
  assign bs.load = ld;
  assign bs.load_value = lv;

  prescaled_counter #(
    .WIDTH(W), .DIV(D), .MODULUS(M), .SATURATE(0)
  ) u_wrap (
    .CLOCK_50(clk),
    .reset(rst),
    .io(bw.slave)
  );

  prescaled_counter #(
    .WIDTH(W), .DIV(D), .MODULUS(M), .SATURATE(1)
  ) u_sat (
    .CLOCK_50(clk),
    .reset(rst),
    .io(bs.slave)
  );

  int checks = 0;
  int errors = 0;

  // model: enabled cycles since last restart, count value, tc
  int ph[2];
  int q[2];
  int tc[2];

  function automatic int exp_tick(int k);
    return (!rst && !ld && en && ((ph[k] + 1) % D == 0)) ? 1 : 0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(int k);
    int lval;
    lval = int'(lv);
    if (rst) begin
      ph[k] = 0;
      q[k] = 0;
      tc[k] = 0;
    end else if (ld) begin
      ph[k] = 0;
      q[k] = (lval >= M) ? M - 1 : lval;
      tc[k] = 0;
    end else begin
      tc[k] = 0;
      if (en) begin
        ph[k] = ph[k] + 1;
        if (ph[k] == D) begin
          ph[k] = 0;
          if (up) begin
            if (q[k] + 1 >= M) begin
              tc[k] = 1;
              if (k == 0) q[k] = 0;
            end else begin
              q[k] = q[k] + 1;
            end
          end else begin
            if (q[k] == 0) begin
              tc[k] = 1;
              if (k == 0) q[k] = M - 1;
            end else begin
              q[k] = q[k] - 1;
            end
          end
        end
      end
    end
  endtask

  task automatic cycle();
    #1;
    chk("tick_wrap", bw.tick, exp_tick(0));
    chk("tick_sat", bs.tick, exp_tick(1));
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    chk("q_wrap", bw.Q, q[0]);
    chk("tc_wrap", bw.tc, tc[0]);
    chk("q_sat", bs.Q, q[1]);
    chk("tc_sat", bs.tc, tc[1]);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0;
      q[k] = 0;
      tc[k] = 0;
    end
    rst = 1'b1;
    en = 1'b1;
    up = 1'b1;
    ld = 1'b0;
    lv = '0;
    @(negedge clk);

    repeat (3) cycle();
    chk("reset_q", bw.Q, 0);
    chk("reset_tc", bw.tc, 0);

    rst = 1'b0;
    repeat (44) cycle();

    ld = 1'b1;
    lv = 4'd0;
    cycle();
    ld = 1'b0;
    up = 1'b0;
    repeat (4) cycle();
    chk("down_wrap_q", bw.Q, 9);
    chk("down_wrap_tc", bw.tc, 1);
    chk("down_sat_q", bs.Q, 0);
    chk("down_sat_tc", bs.tc, 1);
    repeat (4) cycle();
    chk("down_next_q", bw.Q, 8);
    chk("down_next_tc", bw.tc, 0);

    ld = 1'b1;
    lv = 4'd8;
    cycle();
    ld = 1'b0;
    up = 1'b1;
    repeat (12) cycle();
    chk("sat_hold_q", bs.Q, 9);

    ld = 1'b1;
    lv = 4'd12;
    cycle();
    chk("clamp_q", bw.Q, 9);
    ld = 1'b0;
    repeat (3) cycle();
    ld = 1'b1;
    lv = 4'd5;
    cycle();
    chk("load_coinc_q", bw.Q, 5);
    ld = 1'b0;
    repeat (4) cycle();
    chk("after_load_q", bw.Q, 6);

    repeat (2) cycle();
    en = 1'b0;
    repeat (10) cycle();
    en = 1'b1;
    repeat (2) cycle();
    chk("resume_q", bw.Q, 7);

    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    chk("reset_tick_q", bw.Q, 0);
    chk("reset_tick_tc", bw.tc, 0);
    rst = 1'b0;

    repeat (400) begin
      en = ($urandom_range(0, 7) != 0);
      up = $urandom_range(0, 1) != 0;
      ld = ($urandom_range(0, 15) == 0);
      lv = W'($urandom_range(0, 15));
      rst = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
